mxv_stream_engine: RTL
======================

// Module: mxv_stream_engine
// PURPOSE
//  Parametrised N x N matrix-times-vector engine with streaming valid/ready inputs and a buffered result stream.
//  Loads a vector once, then consumes matrix elements row-major. One MAC accumulates each row; row sums go to an output FIFO.
//  Single-clock successor of the fixed 4x4 multi-FIFO datapath. Sits between the value source and the result consumer in the mxv subsystem.
// PARAMETERS
//  N         4                   matrix/vector dimension (>=2)
//  DW        4                   element width (bits)
//  OUT_DEPTH 4                   result FIFO depth (power of 2, >=2)
//  RW        2*DW+$clog2(N)      result width (derived localparam, not overridable)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  rst          in   1    asynchronous, active-low reset
//  i_start      in   1    start a new product (sampled in IDLE only)
//  o_busy       out  1    high whenever FSM != IDLE
//  o_done       out  1    one-cycle pulse after last row sum is pushed
//  i_vec_valid  in   1    vector element valid
//  i_vec_data   in   DW   vector element
//  o_vec_ready  out  1    vector element accepted when valid&ready
//  i_mat_valid  in   1    matrix element valid
//  i_mat_data   in   DW   matrix element, row-major order
//  o_mat_ready  out  1    matrix element accepted when valid&ready
//  o_res_valid  out  1    result FIFO not empty
//  o_res_data   out  RW   head of result FIFO (row 0 first)
//  i_res_ready  in   1    pop result when valid&ready
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, counters/acc/vector regs=0, FIFO emptied; all outputs 0.
//  FSM: IDLE -> LOAD_VEC on i_start. LOAD_VEC -> ROWS after N vector handshakes.
//       ROWS -> DONE after N*N matrix handshakes. DONE -> IDLE after 1 cycle.
//  i_start is ignored outside IDLE. i_vec_valid/i_mat_valid are ignored outside their state.
//  o_vec_ready=1 only in LOAD_VEC. Element k (0..N-1) is stored to vec[k]; col counter wraps N-1 -> 0.
//  o_mat_ready=1 in ROWS, except when col==N-1 and the FIFO is full (count==OUT_DEPTH).
//  o_mat_ready is computed from registered count only; no combinational path from i_res_ready.
//  Matrix handshake at (row r, col c): acc <= (c==0 ? 0 : acc) + m*vec[c].
//  At c==N-1 the sum (acc + m*vec[c]) is pushed to the FIFO on the same edge; acc is then cleared.
//  Latency: o_res_valid rises 1 cycle after the last-column handshake (if FIFO was empty).
//  Widths: product is 2*DW, accumulator is RW. RW cannot overflow, so no saturation or wrap is needed.
//  FIFO: simultaneous push and pop leaves count unchanged; pop when empty is ignored; push never occurs when full.
//  o_done is high in DONE. FIFO contents may still be draining; i_start is accepted in the next IDLE cycle.
//  The FIFO is not cleared by a new i_start.
//  Reset mid-operation aborts the product. Partially accumulated rows and queued results are discarded.
// CONFIGURATION
//  MXV_SIGNED_EN defined: vector and matrix elements are two's complement; products and acc are sign-extended; o_res_data is signed RW.
//  MXV_SIGNED_EN undefined: all operands are unsigned and zero-extended; o_res_data is unsigned.
// TESTING (N=4, DW=4, RW=10 unless noted)
//  Basic (unsigned): vec=[1,2,3,4]; rows [1,1,1,1],[15,15,15,15],[0,0,0,0],[2,0,0,0], i_res_ready=1.
//    -> results 10, 150, 0, 2 in order; o_done pulses once; o_busy falls the cycle after o_done.
//  Backpressure, OUT_DEPTH=2, i_res_ready=0, same data: o_mat_ready drops at row 2 col 3.
//    -> Pop one result -> o_mat_ready returns next cycle; no result lost or duplicated.
//  Stalls: random deassert of i_vec_valid/i_mat_valid gaps -> same results as Basic.
//    i_start pulsed during ROWS -> ignored; exactly one o_done.
//  Signed (MXV_SIGNED_EN): vec all 4'h8 (-8), row all 4'hF (-1) -> result 32.
//    Unsigned build, same data -> result 480.
//  Reset mid-op: assert rst=0 at row 1 col 2 -> o_busy=0, o_res_valid=0 immediately.
//    Then rerun Basic -> results 10, 150, 0, 2.
//  Overlap: start a second product while 2 results of the first remain queued.
//    -> FIFO order is preserved: old results first, then new results.

Source files
------------

// File: rtl/mxv_stream_engine.sv
// mxv_stream_engine: N x N matrix-vector engine with streamed operands and FIFO-buffered row sums.
// Define MXV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module mxv_stream_engine #(
    parameter int N = 4,
    parameter int DW = 4,
    parameter int OUT_DEPTH = 4,
    localparam int RW = 2*DW+$clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    input  logic          i_vec_valid,
    input  logic [DW-1:0] i_vec_data,
    output logic          o_vec_ready,
    input  logic          i_mat_valid,
    input  logic [DW-1:0] i_mat_data,
    output logic          o_mat_ready,
    output logic          o_res_valid,
    output logic [RW-1:0] o_res_data,
    input  logic          i_res_ready
);
    localparam int CW = $clog2(N);
    localparam int AW = $clog2(OUT_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD_VEC, ROWS, DONE} state_t;
    state_t state;
    logic [DW-1:0] vec [N];
    logic [CW-1:0] col, row;
    logic [RW-1:0] acc, m_x, v_x, sum;
    logic [RW-1:0] mem [OUT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic last_col, last_row, vec_hs, mat_hs, push, pop;

    assign last_col = col == CW'(N-1);
    assign last_row = row == CW'(N-1);
    assign o_vec_ready = state == LOAD_VEC;
    // Stall only the row-closing element when the FIFO has no room for its sum
    assign o_mat_ready = state == ROWS && !(last_col && count == (AW+1)'(OUT_DEPTH));
    assign vec_hs = i_vec_valid && o_vec_ready;
    assign mat_hs = i_mat_valid && o_mat_ready;
    assign push = mat_hs && last_col;
    assign o_res_valid = count != '0;
    assign pop = o_res_valid && i_res_ready;
    assign o_res_data = mem[rd_ptr];
`ifdef MXV_SIGNED_EN
    assign m_x = {{(RW-DW){i_mat_data[DW-1]}}, i_mat_data};
    assign v_x = {{(RW-DW){vec[col][DW-1]}}, vec[col]};
`else
    assign m_x = {{(RW-DW){1'b0}}, i_mat_data};
    assign v_x = {{(RW-DW){1'b0}}, vec[col]};
`endif
    assign sum = (col == '0 ? '0 : acc) + m_x * v_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            col <= '0;
            row <= '0;
            acc <= '0;
            for (int k = 0; k < N; k++) vec[k] <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    state <= LOAD_VEC;
                    o_busy <= 1'b1;
                end
                LOAD_VEC: if (vec_hs) begin
                    vec[col] <= i_vec_data;
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) state <= ROWS;
                end
                ROWS: if (mat_hs) begin
                    acc <= last_col ? '0 : sum;
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) row <= last_row ? '0 : row + 1'b1;
                    if (last_col && last_row) begin
                        state <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int k = 0; k < OUT_DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sum;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule
